// File: rtl/rail_crossing_ctrl_if.sv
// Sensor and actuator bundle for rail_crossing_ctrl: the trackside/enable side
// is driven by the master, and the gate and lamp status is driven by the controller (slave).
interface rail_crossing_ctrl_if #(
    parameter int N_TRACKS = 4
) ();
    localparam int OCW = $clog2(N_TRACKS + 1);

    logic                enable;
    logic [N_TRACKS-1:0] rail;
    logic                gate;
    logic                red_light;
    logic                gate_moving;
    logic [OCW-1:0]      occ_count;
    logic [2:0]          state;

    modport master (
        output enable, rail,
        input  gate, red_light, gate_moving, occ_count, state
    );

    modport slave (
        input  enable, rail,
        output gate, red_light, gate_moving, occ_count, state
    );
endinterface

// File: rtl/rail_crossing_ctrl.sv
// Level-crossing controller: per-track sensor debounce, OPEN..RAISING sequencing, registered Moore outputs.
// Optional lamp flashing is enabled by defining RAIL_FLASH_EN.
module rail_crossing_ctrl #(
    parameter int N_TRACKS     = 4,
    parameter int DEB_CYCLES   = 2,
    parameter int WARN_CYCLES  = 8,
    parameter int MOVE_CYCLES  = 6,
    parameter int CLEAR_CYCLES = 4,
    parameter int FLASH_HALF   = 3
) (
    input logic                 clk,
    input logic                 reset,
    rail_crossing_ctrl_if.slave bus
);
    localparam int OCW  = $clog2(N_TRACKS + 1);
    localparam int DCW  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int TMAX = (WARN_CYCLES > MOVE_CYCLES)
                        ? ((WARN_CYCLES > CLEAR_CYCLES) ? WARN_CYCLES : CLEAR_CYCLES)
                        : ((MOVE_CYCLES > CLEAR_CYCLES) ? MOVE_CYCLES : CLEAR_CYCLES);
    localparam int TW   = $clog2(TMAX) + 1;

    localparam logic [DCW-1:0] DEB_LAST = DCW'(DEB_CYCLES - 1);
    localparam logic [TW-1:0]  T_WARN   = TW'(WARN_CYCLES);
    localparam logic [TW-1:0]  T_MOVE   = TW'(MOVE_CYCLES);
    localparam logic [TW-1:0]  T_CLEAR  = TW'(CLEAR_CYCLES);
    localparam logic [TW-1:0]  T_ONE    = TW'(1);

    // Out-of-range parameters pin the gate down rather than let the sequencer misbehave.
    localparam logic PARAMS_OK = (N_TRACKS >= 1) && (N_TRACKS <= 16) && (DEB_CYCLES >= 1) &&
                                 (WARN_CYCLES >= 1) && (MOVE_CYCLES >= 1) &&
                                 (CLEAR_CYCLES >= 1) && (FLASH_HALF >= 1);

    typedef enum logic [2:0] {
        ST_OPEN     = 3'd0,
        ST_WARN     = 3'd1,
        ST_LOWERING = 3'd2,
        ST_CLOSED   = 3'd3,
        ST_HOLD     = 3'd4,
        ST_RAISING  = 3'd5
    } state_e;

    logic [N_TRACKS-1:0] filt_q, filt_d;
    logic [DCW-1:0]      cnt_q [N_TRACKS];
    logic [DCW-1:0]      cnt_d [N_TRACKS];
    logic [OCW-1:0]      occ_q;
    state_e              state_q, state_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic                gate_q, red_q, moving_q;
    logic                any_occ_s, expire_s;
    logic [2:0]          dec_s;

    function automatic logic [OCW-1:0] popcount(input logic [N_TRACKS-1:0] v);
        logic [OCW-1:0] sum;
        sum = '0;
        for (int i = 0; i < N_TRACKS; i++) begin
            sum = sum + OCW'(v[i]);
        end
        return sum;
    endfunction

    // Returns {gate, red, moving}; illegal codes decode to a closed, lit gate.
    function automatic logic [2:0] decode(input state_e s);
        logic [2:0] o;
        case (s)
            ST_OPEN:     o = 3'b000;
            ST_WARN:     o = 3'b010;
            ST_LOWERING: o = 3'b111;
            ST_CLOSED:   o = 3'b110;
            ST_HOLD:     o = 3'b110;
            ST_RAISING:  o = 3'b011;
            default:     o = 3'b110;
        endcase
        return o;
    endfunction

    assign any_occ_s = |filt_q;
    assign expire_s  = (timer_q == T_ONE);
    assign dec_s     = decode(state_d);

    // Per-track debounce: a raw value must disagree with the filter for DEB_CYCLES enabled edges.
    always_comb begin
        filt_d = filt_q;
        for (int i = 0; i < N_TRACKS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (bus.rail[i] != filt_q[i]) begin
                if (cnt_q[i] == DEB_LAST) begin
                    filt_d[i] = bus.rail[i];
                    cnt_d[i]  = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + DCW'(1);
                end
            end else begin
                cnt_d[i] = '0;
            end
        end
    end

    // Crossing sequencer: one shared down-counter, loaded on entry, exits when it reads one.
    always_comb begin
        state_d = state_q;
        timer_d = (timer_q > T_ONE) ? (timer_q - T_ONE) : timer_q;
        case (state_q)
            ST_OPEN: begin
                if (any_occ_s) begin
                    state_d = ST_WARN;
                    timer_d = T_WARN;
                end else begin
                    state_d = ST_OPEN;
                end
            end
            ST_WARN: begin
                if (expire_s) begin
                    state_d = ST_LOWERING;
                    timer_d = T_MOVE;
                end else begin
                    state_d = ST_WARN;
                end
            end
            ST_LOWERING: begin
                if (expire_s) begin
                    state_d = ST_CLOSED;
                end else begin
                    state_d = ST_LOWERING;
                end
            end
            ST_CLOSED: begin
                if (!any_occ_s) begin
                    state_d = ST_HOLD;
                    timer_d = T_CLEAR;
                end else begin
                    state_d = ST_CLOSED;
                end
            end
            ST_HOLD: begin
                if (any_occ_s) begin
                    state_d = ST_CLOSED;
                end else if (expire_s) begin
                    state_d = ST_RAISING;
                    timer_d = T_MOVE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_RAISING: begin
                if (any_occ_s) begin
                    state_d = ST_LOWERING;
                    timer_d = T_MOVE;
                end else if (expire_s) begin
                    state_d = ST_OPEN;
                end else begin
                    state_d = ST_RAISING;
                end
            end
            default: begin
                state_d = ST_LOWERING;
                timer_d = T_MOVE;
            end
        endcase
    end

`ifdef RAIL_FLASH_EN
    localparam int             FW         = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
    localparam logic [FW-1:0]  FLASH_LAST = FW'(FLASH_HALF - 1);
    logic [FW-1:0]             flash_q;

    // Lamp flasher: restarts lit when leaving OPEN, toggles every FLASH_HALF enabled cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            flash_q <= '0;
            red_q   <= 1'b0;
        end else if (bus.enable) begin
            if (state_d == ST_OPEN) begin
                flash_q <= '0;
                red_q   <= 1'b0;
            end else if (state_q == ST_OPEN) begin
                flash_q <= '0;
                red_q   <= 1'b1;
            end else if (flash_q == FLASH_LAST) begin
                flash_q <= '0;
                red_q   <= ~red_q;
            end else begin
                flash_q <= flash_q + FW'(1);
            end
        end
    end
`else
    // Steady lamp, registered from the next state so it lines up with the state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            red_q <= 1'b0;
        end else if (bus.enable) begin
            red_q <= dec_s[1];
        end
    end
`endif

    // Filter, timer, state and registered gate/motion outputs; enable low freezes everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            filt_q   <= '0;
            occ_q    <= '0;
            state_q  <= ST_OPEN;
            timer_q  <= '0;
            gate_q   <= 1'b0;
            moving_q <= 1'b0;
            for (int i = 0; i < N_TRACKS; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (bus.enable) begin
            filt_q   <= filt_d;
            occ_q    <= popcount(filt_d);
            state_q  <= state_d;
            timer_q  <= timer_d;
            gate_q   <= dec_s[2];
            moving_q <= dec_s[0];
            for (int i = 0; i < N_TRACKS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign bus.gate        = gate_q | !PARAMS_OK;
    assign bus.red_light   = red_q;
    assign bus.gate_moving = moving_q;
    assign bus.occ_count   = occ_q;
    assign bus.state       = state_q;
endmodule

// File: tb/tb_rail_crossing_ctrl.sv
// Scoreboard bench for rail_crossing_ctrl: directed scenarios then randomized sensor traffic,
// predicted by a cycle-age reference model of the crossing rules.
module tb_rail_crossing_ctrl;
    localparam int N     = 4;
    localparam int DEB   = 2;
    localparam int WARN  = 8;
    localparam int MOVE  = 6;
    localparam int CLEAR = 4;
    localparam int FH    = 3;

    typedef struct packed {
        logic [2:0] st;
        logic       gate;
        logic       red;
        logic       mov;
        logic [2:0] occ;
    } exp_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;
    exp_t sb_q[$];

    // Reference model: state as an integer plus the number of enabled edges spent in it.
    int          m_state;
    int          m_age;
    int          m_flash_age;
    logic [N-1:0] m_filt;
    int          m_run [N];

    rail_crossing_ctrl_if #(.N_TRACKS(N)) bus ();

    rail_crossing_ctrl #(
        .N_TRACKS(N), .DEB_CYCLES(DEB), .WARN_CYCLES(WARN),
        .MOVE_CYCLES(MOVE), .CLEAR_CYCLES(CLEAR), .FLASH_HALF(FH)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_edge(input logic rst, input logic en, input logic [N-1:0] r);
        logic occ_old;
        int   nxt;
        if (rst) begin
            m_state = 0; m_age = 0; m_flash_age = 0; m_filt = '0;
            for (int i = 0; i < N; i++) m_run[i] = 0;
        end else if (en) begin
            occ_old = |m_filt;
            for (int i = 0; i < N; i++) begin
                if (r[i] != m_filt[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DEB) begin
                        m_filt[i] = r[i];
                        m_run[i]  = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            nxt = m_state;
            case (m_state)
                0: if (occ_old) nxt = 1;
                1: if (m_age == WARN - 1) nxt = 2;
                2: if (m_age == MOVE - 1) nxt = 3;
                3: if (!occ_old) nxt = 4;
                4: if (occ_old) nxt = 3; else if (m_age == CLEAR - 1) nxt = 5;
                5: if (occ_old) nxt = 2; else if (m_age == MOVE - 1) nxt = 0;
                default: nxt = 2;
            endcase
            if (nxt == 0 || (m_state == 0 && nxt == 1)) m_flash_age = 0;
            else m_flash_age++;
            m_age   = (nxt != m_state) ? 0 : m_age + 1;
            m_state = nxt;
        end
    endtask

    function automatic exp_t expected();
        exp_t e;
        e.st   = 3'(m_state);
        e.gate = (m_state == 2 || m_state == 3 || m_state == 4);
        e.mov  = (m_state == 2 || m_state == 5);
`ifdef RAIL_FLASH_EN
        e.red  = (m_state != 0) && (((m_flash_age / FH) % 2) == 0);
`else
        e.red  = (m_state != 0);
`endif
        e.occ  = 3'($countones(m_filt));
        return e;
    endfunction

    task automatic step(input logic rst, input logic en, input logic [N-1:0] r);
        reset      = rst;
        bus.enable = en;
        bus.rail   = r;
        @(posedge clk);
        #1;
        model_edge(rst, en, r);
        sb_q.push_back(expected());
    endtask

    // Monitor: every falling edge, compare the DUT outputs with the oldest prediction.
    always @(negedge clk) begin
        exp_t e;
        exp_t a;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            a.st   = bus.state;
            a.gate = bus.gate;
            a.red  = bus.red_light;
            a.mov  = bus.gate_moving;
            a.occ  = bus.occ_count;
            n_checks++;
            if (a === e) begin
                n_pass++;
            end else begin
                $display("FAIL outputs t=%0t: got st=%0d gate=%0b red=%0b mov=%0b occ=%0d, expected st=%0d gate=%0b red=%0b mov=%0b occ=%0d",
                         $time, a.st, a.gate, a.red, a.mov, a.occ, e.st, e.gate, e.red, e.mov, e.occ);
            end
        end
    end

    initial begin
        logic [N-1:0] r_v;
        logic [N-1:0] r_app;
        logic         rst_v;
        logic         en_v;
        n_checks = 0;
        n_pass   = 0;
        reset      = 1'b1;
        bus.enable = 1'b1;
        bus.rail   = '0;

        // Single train on track 0 through the full closing sequence.
        repeat (2) step(1'b1, 1'b1, 4'b0000);
        repeat (20) step(1'b0, 1'b1, 4'b0001);
        // Brief clear, second track arrives during HOLD.
        repeat (2) step(1'b0, 1'b1, 4'b0000);
        repeat (8) step(1'b0, 1'b1, 4'b0010);
        // Clear long enough to start raising, then a train reappears mid-travel.
        repeat (8) step(1'b0, 1'b1, 4'b0000);
        repeat (12) step(1'b0, 1'b1, 4'b0001);
        repeat (22) step(1'b0, 1'b1, 4'b0000);
        // Single-cycle glitch while open.
        repeat (2) step(1'b1, 1'b1, 4'b0000);
        step(1'b0, 1'b1, 4'b0100);
        repeat (5) step(1'b0, 1'b1, 4'b0000);
        // Enable dropped for ten cycles during the warning period.
        repeat (2) step(1'b1, 1'b1, 4'b0000);
        repeat (5) step(1'b0, 1'b1, 4'b0001);
        repeat (10) step(1'b0, 1'b0, 4'b0001);
        repeat (20) step(1'b0, 1'b1, 4'b0001);
        // Reset while closed.
        step(1'b1, 1'b1, 4'b0001);
        repeat (3) step(1'b0, 1'b1, 4'b0000);

        // Randomized traffic: slowly changing occupancy, glitches, enable gaps, rare resets.
        r_v = '0;
        for (int c = 0; c < 3000; c++) begin
            rst_v = ($urandom_range(0, 399) == 0);
            en_v  = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 11) == 0) r_v[$urandom_range(0, N - 1)] ^= 1'b1;
            r_app = r_v;
            if ($urandom_range(0, 19) == 0) r_app[$urandom_range(0, N - 1)] ^= 1'b1;
            step(rst_v, en_v, r_app);
        end

        @(negedge clk);
        #1;
        n_checks++;
        if (sb_q.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
